// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Package : if_pkg
// Brief   : Shared constants and helpers for the instruction prefetch unit.
// Rev     : 1.0 - initial release
// ============================================================================
package if_pkg;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    // Index width of a queue with 'depth' slots; pointers carry one extra wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage : if_pkg
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : if_fetch_queue
// Brief  : In-order prefetch queue with separate alloc/fill/read pointers.
// Rev    : 1.0 - initial release
// ============================================================================
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int  WORD_BITWIDTH = 32,
    parameter int  DEPTH         = 4,
    localparam int PW            = ptr_width(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     alloc_i,
    input  logic [WORD_BITWIDTH-1:0] alloc_pc_i,
    input  logic                     fill_i,
    input  logic [WORD_BITWIDTH-1:0] fill_data_i,
    input  logic                     consume_i,
    output logic [PW:0]              used_o,
    output logic [PW:0]              outstanding_o,
    output logic                     head_valid_o,
    output logic [WORD_BITWIDTH-1:0] head_pc_o,
    output logic [WORD_BITWIDTH-1:0] head_instr_o
);

    localparam logic [PW:0] c_ptr_one = (PW+1)'(1);

    logic [PW:0]              alloc_q;
    logic [PW:0]              fill_q;
    logic [PW:0]              read_q;
    logic [WORD_BITWIDTH-1:0] pc_q    [DEPTH];
    logic [WORD_BITWIDTH-1:0] instr_q [DEPTH];
    logic [DEPTH-1:0]         filled_q;

    logic [PW-1:0]            w_alloc_idx;
    logic [PW-1:0]            w_fill_idx;
    logic [PW-1:0]            w_read_idx;

    assign w_alloc_idx   = alloc_q[PW-1:0];
    assign w_fill_idx    = fill_q[PW-1:0];
    assign w_read_idx    = read_q[PW-1:0];

    assign used_o        = alloc_q - read_q;
    assign outstanding_o = alloc_q - fill_q;

    assign head_valid_o  = filled_q[w_read_idx] && (used_o != '0);
    assign head_pc_o     = pc_q[w_read_idx];
    assign head_instr_o  = instr_q[w_read_idx];

    // Slot indices of alloc, read and fill never collide while the request
    // and response protocol is honoured, so the three updates are independent.
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_q  <= '0;
            fill_q   <= '0;
            read_q   <= '0;
            filled_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (flush_i) begin
            alloc_q  <= '0;
            fill_q   <= '0;
            read_q   <= '0;
            filled_q <= '0;
        end else begin
            if (alloc_i) begin
                pc_q[w_alloc_idx]     <= alloc_pc_i;
                filled_q[w_alloc_idx] <= 1'b0;
                alloc_q               <= alloc_q + c_ptr_one;
            end
            if (consume_i) begin
                filled_q[w_read_idx]  <= 1'b0;
                read_q                <= read_q + c_ptr_one;
            end
            if (fill_i) begin
                instr_q[w_fill_idx]   <= fill_data_i;
                filled_q[w_fill_idx]  <= 1'b1;
                fill_q                <= fill_q + c_ptr_one;
            end
        end
    end

endmodule : if_fetch_queue
`default_nettype wire

// File: rtl/if_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module : if_prefetch_unit
// Brief  : Sequential instruction prefetcher with redirect, stall and drop.
// Rev    : 1.0 - initial release
// ============================================================================
module if_prefetch_unit
    import if_pkg::*;
#(
    parameter int                       WORD_BITWIDTH = 32,
    parameter int                       DEPTH         = 4,
    parameter logic [WORD_BITWIDTH-1:0] RESET_PC      = '0,
    localparam int                      PW            = ptr_width(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hz_PCWrite,
    input  logic                     redirect_valid,
    input  logic [WORD_BITWIDTH-1:0] redirect_pc,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [WORD_BITWIDTH-1:0] imem_req_addr,
    input  logic                     imem_resp_valid,
    input  logic [WORD_BITWIDTH-1:0] imem_resp_data,
    output logic                     if_valid,
    output logic [WORD_BITWIDTH-1:0] if_pc,
    output logic [WORD_BITWIDTH-1:0] if_instr,
    input  logic                     id_ready
);

    localparam logic [PW:0]              c_depth      = (PW+1)'(DEPTH);
    localparam logic [PW:0]              c_cnt_one    = (PW+1)'(1);
    localparam logic [WORD_BITWIDTH-1:0] c_instr_step = WORD_BITWIDTH'(INSTR_BYTES);

    logic [WORD_BITWIDTH-1:0] fetch_pc_q;
    logic [WORD_BITWIDTH-1:0] fetch_pc_d;
    logic                     held_q;
    logic                     held_d;
    logic [PW:0]              drop_cnt_q;
    logic [PW:0]              drop_cnt_d;

    logic [PW:0]              w_used;
    logic [PW:0]              w_outstanding;
    logic                     w_req_fire;
    logic                     w_resp_take;
    logic                     w_consume;
    logic                     w_unused_pc_lsbs;

    assign w_unused_pc_lsbs = ^redirect_pc[1:0];

    // A request already on the bus is held through a hazard stall; only a
    // redirect (or reset) may withdraw it.
    assign imem_req_valid = !rst && !redirect_valid && (w_used < c_depth)
                            && (held_q || !hz_PCWrite);
    assign imem_req_addr  = fetch_pc_q;

    assign w_req_fire  = imem_req_valid && imem_req_ready;
    assign w_resp_take = imem_resp_valid && !redirect_valid && (drop_cnt_q == '0);
    assign w_consume   = if_valid && id_ready && !redirect_valid;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        held_d     = held_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[WORD_BITWIDTH-1:2], 2'b00};
            held_d     = 1'b0;
            // Everything still in flight becomes stale; a response landing in
            // this very cycle is one of them and is consumed right now.
            drop_cnt_d = drop_cnt_q + w_outstanding
                         - {{PW{1'b0}}, imem_resp_valid};
        end else begin
            held_d = imem_req_valid && !imem_req_ready;
            if (w_req_fire) begin
                fetch_pc_d = fetch_pc_q + c_instr_step;
            end
            if (imem_resp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            held_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            held_q     <= held_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    if_fetch_queue #(
        .WORD_BITWIDTH (WORD_BITWIDTH),
        .DEPTH         (DEPTH)
    ) u_queue (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (redirect_valid),
        .alloc_i       (w_req_fire),
        .alloc_pc_i    (fetch_pc_q),
        .fill_i        (w_resp_take),
        .fill_data_i   (imem_resp_data),
        .consume_i     (w_consume),
        .used_o        (w_used),
        .outstanding_o (w_outstanding),
        .head_valid_o  (if_valid),
        .head_pc_o     (if_pc),
        .head_instr_o  (if_instr)
    );

endmodule : if_prefetch_unit
`default_nettype wire

// File: tb/tb_if_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_if_prefetch_unit
// Brief  : Scoreboard bench for if_prefetch_unit with a latency memory model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hz_PCWrite;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;

    always #5 clk = ~clk;

    if_prefetch_unit #(
        .WORD_BITWIDTH (32),
        .DEPTH         (4),
        .RESET_PC      (32'h0000_0100)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .hz_PCWrite      (hz_PCWrite),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .id_ready        (id_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          lat   = 1;
    int          nfire = 0;
    bit          push_en = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [63:0] sb[$];
    logic [63:0] mon_exp;
    pend_t       pend[$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory: accepts at negedge sampling, answers in order after 'lat' cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) pend.delete();
            else if (imem_req_valid && imem_req_ready)
                pend.push_back('{addr: imem_req_addr, due: cyc + lat});
        end
    end

    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_data(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end
        end
    end

    // Monitor: every ID consume pops one expected {pc, instr} pair.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && if_valid && id_ready && !redirect_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL id_extra: got pc=%h instr=%h, expected no entry", if_pc, if_instr);
                end else begin
                    mon_exp = sb.pop_front();
                    check("id_out", {if_pc, if_instr}, mon_exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "bench timeout");
    end

    task automatic settle();
        #1;
    endtask

    task automatic observe();
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_addr);
            if (push_en) sb.push_back({exp_addr, mem_data(exp_addr)});
            exp_addr = exp_addr + 32'd4;
            nfire++;
        end
    endtask

    task automatic adv();
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        hz_PCWrite = 1'b1;
        while ((sb.size() != 0 || pend.size() != 0) && k < 80) begin
            settle();
            adv();
            k++;
        end
        repeat (3) begin
            settle();
            adv();
        end
        check("drain_sb_empty", sb.size(), 0);
    endtask

    initial begin
        hz_PCWrite     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        id_ready       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_if_pc", if_pc, 0);
        check("rst_if_instr", if_instr, 0);

        // Streaming from RESET_PC with 1-cycle memory
        rst = 1'b0;
        settle();
        check("reset_pc_valid", imem_req_valid, 1);
        check("reset_pc_addr", imem_req_addr, 32'h100);
        adv();
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        push_en        = 1'b1;
        exp_addr       = 32'h100;
        for (int i = 0; i < 8; i++) begin
            settle();
            check("stream_fire", imem_req_valid && imem_req_ready, 1);
            if (i >= 2) check("stream_if_valid", if_valid, 1);
            adv();
        end
        drain();

        // Backpressure: queue fills at 4, then refills one per consume
        id_ready   = 1'b0;
        hz_PCWrite = 1'b0;
        exp_addr   = 32'h120;
        nfire      = 0;
        repeat (8) begin
            settle();
            adv();
        end
        settle();
        check("bp_fire_count", nfire, 4);
        check("bp_req_blocked", imem_req_valid, 0);
        check("bp_if_valid", if_valid, 1);
        adv();
        id_ready = 1'b1;
        nfire    = 0;
        repeat (6) begin
            settle();
            adv();
        end
        check("bp_refill_fires", nfire, 5);
        drain();

        // Hazard stall holds a pending request, then freezes fetch_pc
        hz_PCWrite     = 1'b0;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        settle();
        adv();
        redirect_valid = 1'b0;
        settle();
        check("stall_req_valid", imem_req_valid, 1);
        check("stall_req_addr", imem_req_addr, 32'h300);
        adv();
        hz_PCWrite = 1'b1;
        repeat (2) begin
            settle();
            check("stall_hold_valid", imem_req_valid, 1);
            check("stall_hold_addr", imem_req_addr, 32'h300);
            adv();
        end
        imem_req_ready = 1'b1;
        exp_addr       = 32'h300;
        settle();
        check("stall_fire", imem_req_valid, 1);
        adv();
        repeat (2) begin
            settle();
            check("stall_no_issue", imem_req_valid, 0);
            check("stall_pc_frozen", imem_req_addr, 32'h304);
            adv();
        end
        hz_PCWrite = 1'b0;
        settle();
        check("stall_resume_addr", imem_req_addr, 32'h304);
        adv();
        drain();

        // Redirect with three stale requests in flight (slow memory)
        lat            = 5;
        id_ready       = 1'b0;
        hz_PCWrite     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        settle();
        adv();
        redirect_valid = 1'b0;
        push_en        = 1'b0;
        exp_addr       = 32'h200;
        nfire          = 0;
        repeat (3) begin
            settle();
            adv();
        end
        check("rd_outstanding_fires", nfire, 3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        settle();
        check("rd_req_withdrawn", imem_req_valid, 0);
        adv();
        redirect_valid = 1'b0;
        push_en        = 1'b1;
        exp_addr       = 32'h400;
        settle();
        check("rd_if_valid", if_valid, 0);
        check("rd_req_addr", imem_req_addr, 32'h400);
        adv();
        id_ready = 1'b1;
        drain();

        // Redirect with coincident response and consume, then a second redirect
        lat            = 2;
        hz_PCWrite     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h600;
        settle();
        adv();
        redirect_valid = 1'b0;
        push_en        = 1'b0;
        exp_addr       = 32'h600;
        repeat (3) begin
            settle();
            adv();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h700;
        settle();
        check("dr_head_valid", if_valid, 1);
        check("dr_head_pc", if_pc, 32'h600);
        adv();
        redirect_pc = 32'h800;
        settle();
        check("dr_flushed", if_valid, 0);
        adv();
        redirect_valid = 1'b0;
        push_en        = 1'b1;
        exp_addr       = 32'h800;
        settle();
        check("dr_req_addr", imem_req_addr, 32'h800);
        adv();
        settle();
        adv();
        drain();

        // Misaligned redirect target and PC wrap
        lat            = 1;
        hz_PCWrite     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1002;
        settle();
        adv();
        redirect_valid = 1'b0;
        exp_addr       = 32'h1000;
        settle();
        check("misalign_addr", imem_req_addr, 32'h1000);
        adv();
        drain();
        hz_PCWrite     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        settle();
        adv();
        redirect_valid = 1'b0;
        exp_addr       = 32'hFFFF_FFFC;
        settle();
        check("wrap_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        adv();
        settle();
        check("wrap_zero_addr", imem_req_addr, 32'h0);
        adv();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_if_prefetch_unit
`default_nettype wire

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
Parametrised successor to the single-register IF stage. It generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel. Responses are collected into an in-order prefetch queue of DEPTH slots, and {pc, instr} pairs are presented to ID with a valid/ready handshake. It supports hazard stall, branch/jump redirect with queue flush, and discard of stale in-flight responses.

Parameters:
- WORD_BITWIDTH, 32, width of PC, addresses and instruction words.
- DEPTH, 4, prefetch queue slots, which is also the maximum number of outstanding requests. Must be a power of 2 and ≥2.
- RESET_PC, 0, fetch PC loaded on reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- hz_PCWrite  input  1  hazard hold; 1 = issue no new fetch request.
- redirect_valid  input  1  taken branch/jump from EX; flush and restart.
- redirect_pc  input  WORD_BITWIDTH  redirect target; bits [1:0] ignored and treated as 0.
- imem_req_valid  output  1  request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  WORD_BITWIDTH  fetch address, always word aligned.
- imem_resp_valid  input  1  response valid; one per accepted request, in order, ≥1 cycle after acceptance.
- imem_resp_data  input  WORD_BITWIDTH  instruction word.
- if_valid  output  1  head queue entry filled.
- if_pc  output  WORD_BITWIDTH  PC of the head entry.
- if_instr  output  WORD_BITWIDTH  instruction of the head entry.
- id_ready  input  1  ID consumes the head entry when if_valid & id_ready.

Behaviour:
- Reset: synchronous and active-high. Applies to every register:
  - fetch_pc=RESET_PC
  - alloc/fill/read pointers=0
  - drop_cnt=0
  - imem_req_valid=0, if_valid=0
  - if_pc and if_instr are don't-care (drive 0)
  - Reset mid-operation abandons all state. In-flight memory responses after reset are the memory's responsibility.
- Queue slot state: each slot holds {pc, instr, filled}. Three pointers, each log2(DEPTH) bits with wrap and an extra wrap bit for full/empty:
  - alloc: advanced at request fire.
  - fill: advanced at response accept.
  - read: advanced at ID consume.
  - used = alloc-read, range 0..DEPTH.
- Issue: imem_req_valid = !rst & !redirect_valid & (used < DEPTH) & (held | !hz_PCWrite). imem_req_addr = fetch_pc.
- Hold rule: once asserted, req_valid and addr stay stable until ready. hz_PCWrite does not withdraw a pending request. Only redirect_valid withdraws it.
- Fire (valid&ready): slot[alloc].pc=fetch_pc, filled=0; alloc++; fetch_pc += 4 (wraps modulo 2^WORD_BITWIDTH).
- Response handling:
  - If drop_cnt>0: the response is discarded and drop_cnt--.
  - Otherwise: slot[fill].instr=data, filled=1, fill++.
- Output:
  - if_valid = slot[read].filled & (used>0). if_pc and if_instr come from slot[read].
  - A consume clears filled and does read++.
  - Queue output is registered: a response at cycle t is visible on if_valid at t+1. Best case issue→ID is 2 cycles.
  - Full queue (used=DEPTH): no issue; existing entries drain normally.
- Redirect (redirect_valid=1 at cycle t). Redirect has priority over every simultaneous event. At t+1:
  - fetch_pc = {redirect_pc[W-1:2],2'b00}
  - alloc=fill=read=0, all filled=0, if_valid=0
  - drop_cnt = drop_cnt + (alloc-fill) - (resp_valid at t ? 1:0). Max DEPTH, so the counter is log2(DEPTH)+1 bits.
  - A response arriving at t is dropped, and a consume at t is ignored, since ID is flushed by the same redirect.
  - First new request may fire at t+1.
- Back-to-back redirects accumulate drop_cnt correctly via the formula above.
- hz_PCWrite and redirect in the same cycle: redirect wins.

Decomposition:
- Package if_pkg:
  - INSTR_BYTES=4
  - NOP_INSTR=32'h0000_0013
  - helper function for the pointer width clog2(DEPTH)
- One sub-module, if_fetch_queue: slot array with alloc/fill/read pointers, flush input, filled flags and head outputs.
- Top level holds fetch_pc, issue logic, drop_cnt and redirect handling.

Test Plan:
- Reset with RESET_PC=0x100, then rst=0 with ready=1 and 1-cycle response latency: addresses 0x100, 0x104, 0x108… issue on consecutive cycles. ID sees if_pc in the same order with matching instr, one per cycle after the pipeline fills.
- Backpressure with DEPTH=4 and id_ready=0: exactly 4 requests fire, then req_valid=0. Raise id_ready: one new request fires per consumed entry, and no entry is lost or duplicated.
- Stall: assert hz_PCWrite while req_valid=1 and ready=0. Request stays asserted with a stable addr until ready. After the fire, no new request is issued while hz_PCWrite=1, and fetch_pc stays frozen.
- Redirect with 3 outstanding (0x200–0x208), redirect_pc=0x400 with no response that cycle:
  - Next cycle: if_valid=0 and req_addr=0x400.
  - The next 3 responses are discarded.
  - First ID output is pc=0x400 with the 4th response's data.
- Redirect coinciding with a response and a consume, then a second redirect 1 cycle later: drop_cnt is computed per the formula. Only the final target's instructions reach ID.
- Redirect to 0x1002 (misaligned) and fetch_pc wrap from 0xFFFF_FFFC: addr=0x1000; the wrap case yields the next fetch at 0x0000_0000.
